morphle_cfg_loader: RTL
=======================

MORPHLE_CFG_LOADER -- requirements
Module: morphle_cfg_loader

Interface
REQ-001 Parameter: CHAINW, 16, number of parallel configuration chains, one per yblock column.
REQ-002 Parameter: FIFO_DEPTH, 4, entries in each of the TX and RX word FIFOs; power of two, at least 2.
REQ-003 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-004 wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-005 wb_rst_ni  in  1  asynchronous active-low reset.
REQ-006 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write-enable.
REQ-007 wbs_sel_i  in  4  byte lanes.
REQ-008 wbs_adr_i  in  32  byte address; only bits [3:2] are decoded.
REQ-009 wbs_dat_i  in  32  write data.
REQ-010 wbs_ack_o  out  1  transfer acknowledge.
REQ-011 wbs_dat_o  out  32  read data.
REQ-012 cfg_reset_o  out  1  freeze-and-clear line to the cell array.
REQ-013 confclk_o  out  1  configuration strobe to the cell array.
REQ-014 cbitin_o  out  CHAINW  configuration bits into the top cells.
REQ-015 cbitout_i  in  CHAINW  configuration bits returned from the bottom cells.

Function
REQ-016 Register map: 0x0 CTRL, 0x4 DATA, 0x8 STATUS, 0xC TIMING.
REQ-017 CTRL bit0 SHALL drive cfg_reset_o directly; CTRL bit1 written as 1 SHALL abort the engine (self-clearing, reads back 0).
REQ-018 TIMING SHALL hold SETUP[7:0], HIGH[15:8] and LOW[23:16] cycle counts; a field value of 0 SHALL be treated as 1.
REQ-019 A DATA write with sel[1:0] = 2'b11 SHALL push wbs_dat_i[CHAINW-1:0] into the TX FIFO; if the FIFO is full, the word SHALL be dropped and STATUS.txovf set.
REQ-020 A DATA read SHALL return and pop the RX FIFO head; if the FIFO is empty, it SHALL return 0, pop nothing, and set STATUS.rxunf.
REQ-021 STATUS read bits: [0] busy, [1] txfull, [2] txempty, [3] rxfull, [4] rxempty, [5] txovf, [6] rxunf. Writing 1 to bit 5 or bit 6 SHALL clear that bit.
REQ-022 wbs_ack_o SHALL rise in the cycle after cyc&stb and last exactly one cycle; it SHALL never assert in two consecutive cycles.
REQ-023 wbs_dat_o SHALL be valid while wbs_ack_o is high and 0 otherwise; unmapped bits SHALL read 0.
REQ-024 Engine FSM states: IDLE, SETUP, HIGH, LOW, CAPT.
REQ-025 IDLE -> SETUP when the TX FIFO is non-empty and cfg_reset_o=0. On that transition the TX FIFO is popped and the word is loaded into cbitin_o.
REQ-026 SETUP SHALL last SETUP cycles with confclk_o=0, then -> HIGH.
REQ-027 HIGH SHALL last HIGH cycles with confclk_o=1, then -> LOW.
REQ-028 LOW SHALL last LOW cycles with confclk_o=0, then -> CAPT.
REQ-029 CAPT SHALL push cbitout_i into the RX FIFO and return to IDLE; if the RX FIFO is full, the engine SHALL stall in CAPT with no loss, and no new strobe may start.
REQ-030 cbitin_o SHALL be held stable from SETUP entry until the next load.
REQ-031 busy SHALL be 1 whenever the state is not IDLE.
REQ-032 Minimum strobe period SHALL be SETUP+HIGH+LOW+2 cycles.
REQ-033 Abort or cfg_reset_o=1 mid-strobe: next cycle -> IDLE, confclk_o=0, TX FIFO flushed; the RX FIFO SHALL be kept.
REQ-034 A simultaneous push and pop on either FIFO SHALL both take effect, leaving the count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-035 While wb_rst_ni=0, all outputs SHALL be: wbs_ack_o=0, wbs_dat_o=0, confclk_o=0, cbitin_o=0, cfg_reset_o=1.
REQ-036 Reset SHALL put the FSM in IDLE, empty both FIFOs, clear the sticky bits, and load TIMING=0x010101.

Structure
REQ-037 Package morphle_cfg_pkg SHALL hold the register offsets, STATUS bit positions, TIMING field positions, the FSM state enum, and the TIMING reset constant.
REQ-038 A single sub-module morphle_word_fifo (synchronous, parameterised width/depth, full/empty flags) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-039 Reset release -> cfg_reset_o=1 and STATUS=0x14. Write CTRL=0, then DATA=0xA5A5 with TIMING=0x010101 -> cbitin_o=0xA5A5, confclk_o high for exactly 1 cycle, RX receives the cbitout_i value.
REQ-040 TIMING=0x030201 with three DATA writes -> three strobes, each confclk high for 2 cycles, period 8 cycles, RX FIFO read back in order.
REQ-041 Five DATA writes issued while cfg_reset_o=1 (depth 4) -> txfull=1, txovf=1, fifth word lost; writing 0x20 to STATUS clears txovf.
REQ-042 Fill the RX FIFO (4 strobes), then queue a 5th word -> engine stalls in CAPT with busy=1; one DATA read -> stall releases and the 5th capture lands.
REQ-043 Write CTRL=0x2 during HIGH -> confclk_o=0 next cycle, FSM in IDLE, txempty=1, RX contents preserved.
REQ-044 DATA read with the RX FIFO empty -> returns 0, rxunf=1, ack pulse exactly one cycle.

Source files
------------

// File: rtl/morphle_cfg_pkg.sv
// Shared definitions for the Morphle configuration loader: register map,
// STATUS/TIMING field positions, engine states and reset constants.
package morphle_cfg_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_TIMING = 2'd3;

  localparam int CTRL_CFGRST = 0;
  localparam int CTRL_ABORT  = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_TXFULL  = 1;
  localparam int ST_TXEMPTY = 2;
  localparam int ST_RXFULL  = 3;
  localparam int ST_RXEMPTY = 4;
  localparam int ST_TXOVF   = 5;
  localparam int ST_RXUNF   = 6;

  localparam int TIM_SETUP_LSB = 0;
  localparam int TIM_HIGH_LSB  = 8;
  localparam int TIM_LOW_LSB   = 16;

  localparam logic [23:0] TIMING_RST = 24'h010101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_CAPT
  } state_t;

  // A programmed phase length of zero still needs one cycle on the array.
  function automatic logic [7:0] phase_len(input logic [7:0] f);
    return (f == 8'd0) ? 8'd1 : f;
  endfunction

endpackage

// File: rtl/morphle_word_fifo.sv
// Small synchronous word FIFO with full/empty flags and a flush input;
// used for both the TX (to array) and RX (from array) word queues.
module morphle_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign w_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_push = i_push & (~o_full | w_pop) & ~i_flush;

  assign o_data = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/morphle_cfg_loader.sv
// Wishbone-attached loader that shifts configuration words into the Morphle
// cell array through CHAINW parallel chains and captures what falls out.
module morphle_cfg_loader
  import morphle_cfg_pkg::*;
#(
  parameter int CHAINW     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              cfg_reset_o,
  output logic              confclk_o,
  output logic [CHAINW-1:0] cbitin_o,
  input  logic [CHAINW-1:0] cbitout_i
);

  logic              r_ack;
  logic [31:0]       r_dat;
  logic              r_cfg_reset;
  logic [23:0]       r_timing;
  logic              r_txovf;
  logic              r_rxunf;
  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_confclk;
  logic [CHAINW-1:0] r_cbitin;

  logic              w_req;
  logic              w_wr;
  logic              w_rd;
  logic [1:0]        w_adr;
  logic              w_tx_push_req;
  logic              w_tx_ovf;
  logic              w_abort;
  logic              w_kill;
  logic              w_start;
  logic              w_rx_pop;
  logic              w_rx_push;
  logic              w_rx_unf;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic [CHAINW-1:0] w_tx_head;
  logic [CHAINW-1:0] w_rx_head;
  logic [7:0]        w_setup;
  logic [7:0]        w_high;
  logic [7:0]        w_low;
  logic [31:0]       w_status;
  logic [31:0]       w_rdata;
  logic              w_unused_ok;

  assign w_unused_ok = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:24]};

  // Gating with r_ack keeps acknowledges one cycle long and never back to back.
  assign w_req = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr  = w_req & wbs_we_i;
  assign w_rd  = w_req & ~wbs_we_i;
  assign w_adr = wbs_adr_i[3:2];

  assign w_tx_push_req = w_wr && (w_adr == REG_DATA) && (wbs_sel_i[1:0] == 2'b11);
  assign w_abort       = w_wr && (w_adr == REG_CTRL) && wbs_dat_i[CTRL_ABORT];
  assign w_kill        = w_abort | (r_cfg_reset & (r_state != S_IDLE));
  assign w_start       = (r_state == S_IDLE) & ~w_tx_empty & ~r_cfg_reset & ~w_abort;
  assign w_tx_ovf      = w_tx_push_req & w_tx_full & ~w_start & ~w_kill;
  assign w_rx_pop      = w_rd && (w_adr == REG_DATA) && !w_rx_empty;
  assign w_rx_unf      = w_rd && (w_adr == REG_DATA) && w_rx_empty;
  assign w_rx_push     = (r_state == S_CAPT) & ~w_kill & (~w_rx_full | w_rx_pop);

  assign w_setup = r_timing[TIM_SETUP_LSB +: 8];
  assign w_high  = r_timing[TIM_HIGH_LSB  +: 8];
  assign w_low   = r_timing[TIM_LOW_LSB   +: 8];

  morphle_word_fifo #(.WIDTH(CHAINW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_flush (w_kill),
    .i_push  (w_tx_push_req),
    .i_data  (wbs_dat_i[CHAINW-1:0]),
    .i_pop   (w_start),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  morphle_word_fifo #(.WIDTH(CHAINW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_flush (1'b0),
    .i_push  (w_rx_push),
    .i_data  (cbitout_i),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_comb begin
    w_status             = '0;
    w_status[ST_BUSY]    = (r_state != S_IDLE);
    w_status[ST_TXFULL]  = w_tx_full;
    w_status[ST_TXEMPTY] = w_tx_empty;
    w_status[ST_RXFULL]  = w_rx_full;
    w_status[ST_RXEMPTY] = w_rx_empty;
    w_status[ST_TXOVF]   = r_txovf;
    w_status[ST_RXUNF]   = r_rxunf;
  end

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      REG_CTRL:   w_rdata[CTRL_CFGRST] = r_cfg_reset;
      REG_DATA:   w_rdata = w_rx_empty ? 32'd0 : 32'(w_rx_head);
      REG_STATUS: w_rdata = w_status;
      REG_TIMING: w_rdata = {8'd0, r_timing};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_cfg_reset <= 1'b1;
      r_timing    <= TIMING_RST;
      r_txovf     <= 1'b0;
      r_rxunf     <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;
      if (w_wr && (w_adr == REG_CTRL))   r_cfg_reset <= wbs_dat_i[CTRL_CFGRST];
      if (w_wr && (w_adr == REG_TIMING)) r_timing    <= wbs_dat_i[23:0];
      if (w_tx_ovf)
        r_txovf <= 1'b1;
      else if (w_wr && (w_adr == REG_STATUS) && wbs_dat_i[ST_TXOVF])
        r_txovf <= 1'b0;
      if (w_rx_unf)
        r_rxunf <= 1'b1;
      else if (w_wr && (w_adr == REG_STATUS) && wbs_dat_i[ST_RXUNF])
        r_rxunf <= 1'b0;
    end
  end

  // Strobe engine: counters hold (phase length - 1) so each phase lasts exactly its programmed cycles.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_confclk <= 1'b0;
      r_cbitin  <= '0;
    end else if (w_kill) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_confclk <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cbitin <= w_tx_head;
            r_cnt    <= phase_len(w_setup) - 8'd1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_state   <= S_HIGH;
            r_confclk <= 1'b1;
            r_cnt     <= phase_len(w_high) - 8'd1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_HIGH: begin
          if (r_cnt == 8'd0) begin
            r_state   <= S_LOW;
            r_confclk <= 1'b0;
            r_cnt     <= phase_len(w_low) - 8'd1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_LOW: begin
          if (r_cnt == 8'd0) r_state <= S_CAPT;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        S_CAPT: begin
          if (w_rx_push) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign cfg_reset_o = r_cfg_reset;
  assign confclk_o   = r_confclk;
  assign cbitin_o    = r_cbitin;

endmodule
